// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder: default sizes, halt word and
// FSM state encodings.
package instr_feeder_pkg;

   localparam int unsigned DEF_DATA_W  = 16;
   localparam int unsigned DEF_ADDR_W  = 5;
   localparam int unsigned DEF_TIMEOUT = 15;
   localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_FETCH = 3'd1;
   localparam state_t S_ISSUE = 3'd2;
   localparam state_t S_WAIT  = 3'd3;
   localparam state_t S_HALT  = 3'd4;
   localparam state_t S_ERR   = 3'd5;

   function automatic logic is_busy(input state_t s);
      return (s == S_FETCH) || (s == S_ISSUE) || (s == S_WAIT);
   endfunction

   function automatic logic can_start(input state_t s);
      return (s == S_IDLE) || (s == S_HALT) || (s == S_ERR);
   endfunction

endpackage

// File: rtl/instr_feeder_prog_mem.sv
// Program store: one write port, one registered read port; contents survive reset.
module prog_mem
   import instr_feeder_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/instr_feeder.sv
// Processor Din/Run/Done initiator: steps through a loaded program, issuing one
// word per handshake and stopping on length, halt word or Done timeout.
module instr_feeder
   import instr_feeder_pkg::*;
#(
   parameter int unsigned       DATA_W    = DEF_DATA_W,
   parameter int unsigned       ADDR_W    = DEF_ADDR_W,
   parameter int unsigned       TIMEOUT   = DEF_TIMEOUT,
   parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
   input  logic              clk,
   input  logic              Rest,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              start,
   input  logic              Done_i,
   output logic [DATA_W-1:0] Din_o,
   output logic              Run_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              busy,
   output logic              halted,
   output logic              timeout_err,
   output logic [15:0]       instr_cnt
);

   localparam int unsigned       LEN_W  = ADDR_W + 1;
   localparam int unsigned       WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [LEN_W-1:0]  DEPTH  = LEN_W'(2**ADDR_W);
   localparam logic [WCNT_W-1:0] WLAST  = WCNT_W'(TIMEOUT - 1);

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    pc_next;
   logic [WCNT_W-1:0]   wcnt;
   logic [DATA_W-1:0]   rd_data;
   logic                mem_we;

   assign mem_we  = load_en && (state == S_IDLE);
   assign pc_next = LEN_W'(pc) + LEN_W'(1);

   prog_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .rd_addr (pc),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (Rest) begin
         state     <= S_IDLE;
         Din_o     <= '0;
         Run_o     <= 1'b0;
         pc        <= '0;
         len_q     <= '0;
         wcnt      <= '0;
         instr_cnt <= '0;
      end else begin
         Run_o <= 1'b0;
         case (state)
            S_IDLE, S_HALT, S_ERR: begin
               if (start) begin
                  // clamp so pc can never wrap past the last address
                  len_q     <= (prog_len > DEPTH) ? DEPTH : prog_len;
                  pc        <= '0;
                  wcnt      <= '0;
                  instr_cnt <= '0;
                  state     <= (prog_len == '0) ? S_HALT : S_FETCH;
               end
            end
            S_FETCH: state <= S_ISSUE;
            S_ISSUE: begin
               if (rd_data == HALT_WORD) begin
                  state <= S_HALT;
               end else begin
                  Din_o <= rd_data;
                  Run_o <= 1'b1;
                  wcnt  <= '0;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Done takes priority over the timeout on the final wait cycle
               if (Done_i) begin
                  if (instr_cnt != '1)
                     instr_cnt <= instr_cnt + 16'd1;
                  if (pc_next == len_q) begin
                     state <= S_HALT;
                  end else begin
                     pc    <= pc_next[ADDR_W-1:0];
                     state <= S_FETCH;
                  end
               end else if (wcnt == WLAST) begin
                  state <= S_ERR;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign pc_o        = pc;
   assign busy        = is_busy(state);
   assign halted      = (state == S_HALT);
   assign timeout_err = (state == S_ERR);

endmodule

// File: tb/tb_instr_feeder.sv
// Randomised bench for instr_feeder: a program-level model predicts the issued
// word stream and end state; a responder answers Run_o with Done_i.
module tb_instr_feeder;

   localparam int          ADDR_W   = 5;
   localparam int          DEPTH    = 32;
   localparam int          TMO      = 15;
   localparam logic [15:0] HALT     = 16'hFFFF;
   localparam int          RAND_DLY = 99;
   localparam int          BUDGET   = 2000;

   logic        clk = 1'b0;
   logic        Rest = 1'b0;
   logic        load_en = 1'b0;
   logic [4:0]  load_addr = '0;
   logic [15:0] load_data = '0;
   logic [5:0]  prog_len = '0;
   logic        start = 1'b0;
   logic        Done_i = 1'b0;
   logic [15:0] Din_o;
   logic        Run_o;
   logic [4:0]  pc_o;
   logic        busy, halted, timeout_err;
   logic [15:0] instr_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] mem_m [DEPTH];
   int          issued_q [$];
   int          exp_q [$];
   int          first_run, err_step, finished;

   instr_feeder #(.DATA_W(16), .ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
      .clk(clk), .Rest(Rest), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .prog_len(prog_len), .start(start), .Done_i(Done_i),
      .Din_o(Din_o), .Run_o(Run_o), .pc_o(pc_o), .busy(busy), .halted(halted),
      .timeout_err(timeout_err), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      Rest = 1'b1; start = 1'b0; Done_i = 1'b0; load_en = 1'b0;
      step();
      Rest = 1'b0;
   endtask

   task automatic load_word(input int addr, input logic [15:0] data);
      load_en = 1'b1; load_addr = 5'(addr); load_data = data;
      step();
      load_en = 1'b0;
      mem_m[addr] = data;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_din"}, Din_o, 0);
      check({tag, "_run"}, Run_o, 0);
      check({tag, "_pc"}, pc_o, 0);
      check({tag, "_flags"}, {busy, halted, timeout_err}, 0);
      check({tag, "_cnt"}, instr_cnt, 0);
   endtask

   // dly: cycles from Run_o to Done_i; <0 never answers, RAND_DLY picks 0..6 per word
   task automatic run_prog(input int len, input int dly, input int abort_after, input bit poke);
      int  done_at;
      bit  prev_run;
      int  d;
      start = 1'b1; prog_len = 6'(len);
      done_at = -1; prev_run = 1'b0; first_run = -1; err_step = -1; finished = 0;
      issued_q.delete();
      for (int s = 1; s <= BUDGET; s++) begin
         step();
         start = 1'b0; Done_i = 1'b0; load_en = 1'b0;
         if (Run_o) begin
            check("run_single_cycle", {31'd0, prev_run}, 0);
            issued_q.push_back(Din_o);
            if (first_run < 0) first_run = s;
            d = (dly == RAND_DLY) ? int'($urandom_range(0, 6)) : dly;
            done_at = (dly < 0) ? -1 : s + d;
            if (poke && issued_q.size() == 1) begin
               start = 1'b1; load_en = 1'b1; load_addr = '0;
               load_data = 16'hBEEF; prog_len = 6'd1;
            end
         end
         prev_run = Run_o;
         if (timeout_err && err_step < 0) err_step = s;
         if (halted || timeout_err) begin
            finished = 1;
            break;
         end
         if (abort_after > 0 && issued_q.size() == abort_after) begin
            Rest = 1'b1;
            finished = 1;
            break;
         end
         if (s == done_at) Done_i = 1'b1;
      end
      check("prog_finished", finished, 1);
   endtask

   task automatic check_prog(input string tag, input int len);
      int exp_pc;
      exp_q.delete();
      for (int i = 0; i < len; i++) begin
         if (mem_m[i] == HALT) break;
         exp_q.push_back(mem_m[i]);
      end
      exp_pc = (exp_q.size() < len) ? exp_q.size() : len - 1;
      if (len == 0) exp_pc = 0;
      check({tag, "_nrun"}, issued_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < issued_q.size(); i++)
         check({tag, "_din"}, issued_q[i], exp_q[i]);
      if (exp_q.size() > 0) check({tag, "_latency"}, first_run, 3);
      check({tag, "_flags"}, {busy, halted, timeout_err}, 3'b010);
      check({tag, "_pc"}, pc_o, exp_pc);
      check({tag, "_cnt"}, instr_cnt, exp_q.size());
   endtask

   initial begin
      // 1: reset state, Done_i ignored in IDLE
      do_reset();
      check_reset_outputs("reset");
      for (int i = 0; i < 3; i++) begin
         Done_i = 1'b1;
         step();
         Done_i = 1'b0;
         check("idle_done_cnt", instr_cnt, 0);
         check("idle_done_busy", {busy, Run_o}, 0);
      end
      for (int i = 0; i < DEPTH; i++)
         load_word(i, 16'($urandom_range(0, 16'hFFFE)));

      // 2: three-word program, Done two cycles after each Run
      load_word(0, 16'h1203);
      load_word(1, 16'h2401);
      load_word(2, 16'h0005);
      run_prog(3, 2, 0, 1'b0);
      check_prog("prog3", 3);

      // 3: halt word at address 1
      do_reset();
      load_word(1, HALT);
      run_prog(4, 2, 0, 1'b0);
      check_prog("haltword", 4);

      // 4: no answer -> ERR after 15 wait cycles; Done on cycle 15 -> no error
      do_reset();
      load_word(1, 16'h0007);
      run_prog(3, -1, 0, 1'b0);
      check("tmo_err_step", err_step - first_run, TMO);
      check("tmo_flags", {busy, halted, timeout_err}, 3'b001);
      check("tmo_nrun", issued_q.size(), 1);
      check("tmo_cnt", instr_cnt, 0);
      run_prog(3, TMO - 1, 0, 1'b0);
      check_prog("tmo_edge", 3);

      // 5: reset during wait of word 2, late Done ignored, rerun from pc 0
      do_reset();
      run_prog(3, 3, 2, 1'b0);
      step();
      Rest = 1'b0;
      check_reset_outputs("abort");
      Done_i = 1'b1;
      step();
      Done_i = 1'b0;
      step();
      check_reset_outputs("late_done");
      run_prog(3, 1, 0, 1'b0);
      check_prog("rerun", 3);

      // 6: start/load while busy ignored; zero length halts with no Run
      do_reset();
      run_prog(3, 4, 0, 1'b1);
      check_prog("busy_poke", 3);
      do_reset();
      run_prog(1, 0, 0, 1'b0);
      check_prog("mem_kept", 1);
      run_prog(0, 0, 0, 1'b0);
      check_prog("len0", 0);

      // randomised programs, sometimes loading word 0 in the start cycle
      for (int it = 0; it < 24; it++) begin
         int len;
         do_reset();
         for (int k = 0; k < int'($urandom_range(0, 4)); k++)
            load_word($urandom_range(0, DEPTH - 1),
                      ($urandom_range(0, 7) == 0) ? HALT : 16'($urandom));
         len = $urandom_range(0, DEPTH);
         if ($urandom_range(0, 2) == 0) begin
            load_en = 1'b1; load_addr = '0; load_data = 16'($urandom_range(0, 16'hFFFE));
            mem_m[0] = load_data;
         end
         run_prog(len, RAND_DLY, 0, 1'b0);
         check_prog("rand", len);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
